reg_page_display: RTL



---
 rtl/reg_page_display.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/reg_page_display.sv
// reg_page_display: shows one pair of the core's 16-bit register taps as eight
// hex digits on a time-multiplexed, active-low seven-segment bank.
// A snapshot of the selected pair is taken at every frame start, so the
// display never tears. The page is either chosen by page_sel or rotated
// automatically every AUTO_PAGE_FRAMES frames.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the leading zero nibbles
// of each register. Nibble [3:0] always stays lit.
module reg_page_display #(
    parameter int SCAN_DIV         = 1024,
    parameter int AUTO_PAGE_FRAMES = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] r0,
    input  logic [15:0] r1,
    input  logic [15:0] r2,
    input  logic [15:0] r3,
    input  logic [15:0] r4,
    input  logic [15:0] r5,
    input  logic [15:0] r6,
    input  logic [15:0] r7,
    input  logic [1:0]  page_sel,
    input  logic        auto_page,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  digit_en,
    output logic [1:0]  cur_page,
    output logic        frame_tick
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int FCNT_W = (AUTO_PAGE_FRAMES > 1) ? $clog2(AUTO_PAGE_FRAMES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(AUTO_PAGE_FRAMES - 1);

    // PRIME: waiting for the first snapshot after reset; SCAN: normal scanning
    typedef enum logic {ST_PRIME, ST_SCAN} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic [2:0]          digit_idx;
    logic [FCNT_W-1:0]   frame_cnt;
    logic [FCNT_W-1:0]   fcnt_nxt;
    logic [1:0]          page_nxt;
    logic                load_snap;
    logic [15:0]         even_q;
    logic [15:0]         odd_q;
    logic [7:0][15:0]    taps;
    logic                div_last;
    logic                frame_end;
    logic [15:0]         src;
    logic [1:0]          nib_pos;
    logic [3:0]          nib;
    logic                blank;

    // Taps gathered into one packed array so a page selects index {page, lsb}
    assign taps = {r7, r6, r5, r4, r3, r2, r1, r0};

    assign div_last  = (div_cnt == DIV_LAST);
    assign frame_end = div_last && (digit_idx == 3'd7);

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // State register for the priming FSM
    always_ff @(posedge clock) begin
        if (reset) state <= ST_PRIME;
        else       state <= state_nxt;
    end

    // Next state plus page / frame-count decisions at priming and frame ends
    always_comb begin
        state_nxt = state;
        load_snap = 1'b0;
        page_nxt  = cur_page;
        fcnt_nxt  = frame_cnt;
        case (state)
            ST_PRIME: begin
                state_nxt = ST_SCAN;
                load_snap = 1'b1;
                page_nxt  = auto_page ? 2'd0 : page_sel;
                fcnt_nxt  = '0;
            end
            default: begin
                if (frame_end) begin
                    load_snap = 1'b1;
                    if (auto_page) begin
                        if (frame_cnt == FCNT_LAST) begin
                            fcnt_nxt = '0;
                            page_nxt = cur_page + 2'd1;
                        end else begin
                            fcnt_nxt = frame_cnt + FCNT_W'(1);
                        end
                    end else begin
                        page_nxt = page_sel;
                        fcnt_nxt = '0;
                    end
                end
            end
        endcase
    end

    // Scan counters, page register and frame-coherent snapshot
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt    <= '0;
            digit_idx  <= 3'd0;
            frame_cnt  <= '0;
            cur_page   <= 2'd0;
            frame_tick <= 1'b0;
            even_q     <= 16'h0000;
            odd_q      <= 16'h0000;
        end else begin
            cur_page   <= page_nxt;
            frame_cnt  <= fcnt_nxt;
            frame_tick <= load_snap;
            if (load_snap) begin
                even_q <= taps[{page_nxt, 1'b0}];
                odd_q  <= taps[{page_nxt, 1'b1}];
            end
            // counters hold at zero during priming so scanning starts at digit 0
            if (state == ST_SCAN) begin
                div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
                if (div_last) digit_idx <= digit_idx + 3'd1;
            end
        end
    end

    // Nibble selection: low four digits show the odd register, high four the even
    always_comb begin
        src     = digit_idx[2] ? even_q : odd_q;
        nib_pos = digit_idx[1:0];
        nib     = src[{nib_pos, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank   = (nib_pos != 2'd0) && ((src >> {nib_pos, 2'b00}) == 16'h0000);
`else
        blank   = 1'b0;
`endif
    end

    // Registered display drive, one cycle behind digit_idx and the snapshot
    always_ff @(posedge clock) begin
        if (reset || state != ST_SCAN) begin
            seg      <= 7'h7F;
            dp       <= 1'b1;
            digit_en <= 8'hFF;
        end else begin
            seg      <= blank ? 7'h7F : hex_glyph(nib);
            dp       <= (digit_idx != 3'd4);
            digit_en <= 8'hFF ^ (8'd1 << digit_idx);
        end
    end

endmodule
